// File: rtl/fifo_pkg.sv
// Shared definitions for the threshold FIFO: parameter legality check and
// the packed error-flag record.
package fifo_pkg;

    function automatic bit params_legal(input int depth, input int afull_thr, input int aempty_thr);
        bit pow2_ok;
        bit afull_ok;
        bit aempty_ok;
        pow2_ok   = (depth >= 32'sd2) && ((depth & (depth - 32'sd1)) == 32'sd0);
        afull_ok  = (afull_thr >= 32'sd1) && (afull_thr <= depth);
        aempty_ok = (aempty_thr >= 32'sd0) && (aempty_thr <= depth - 32'sd1);
        return pow2_ok && afull_ok && aempty_ok;
    endfunction

    typedef struct packed {
        logic ovf;
        logic unf;
    } err_flags_t;

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port storage: registered write port, combinational read port.
// Contents are deliberately not reset.
module fifo_mem_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOG2_DEPTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [LOG2_DEPTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FWFT FIFO with programmable almost-full/empty thresholds,
// fill level, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_thr
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int LOG2_DEPTH = $clog2(FIFO_DEPTH),
    parameter int AFULL_THR  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THR = 1
) (
    input  logic                  CLKip,
    input  logic                  RSTni,
    input  logic                  FLUSHi,
    input  logic                  WEi,
    input  logic [DATA_WIDTH-1:0] DATAi,
    input  logic                  RDi,
    input  logic                  ERR_CLRi,
    output logic [DATA_WIDTH-1:0] DATAo,
    output logic                  FULLo,
    output logic                  EMPTYo,
    output logic                  AFULLo,
    output logic                  AEMPTYo,
    output logic [LOG2_DEPTH:0]   LEVELo,
    output logic                  OVFo,
    output logic                  UNFo
);

    typedef logic [LOG2_DEPTH:0]   level_t;
    typedef logic [LOG2_DEPTH-1:0] ptr_t;

    localparam level_t DEPTH_L   = level_t'(FIFO_DEPTH);
    localparam level_t AFULL_L   = level_t'(AFULL_THR);
    localparam level_t AEMPTY_L  = level_t'(AEMPTY_THR);
    localparam level_t LEVEL_ONE = level_t'(1'b1);
    localparam ptr_t   PTR_ONE   = ptr_t'(1'b1);

    if (!params_legal(FIFO_DEPTH, AFULL_THR, AEMPTY_THR)) begin : g_bad_params
        $error("sync_fifo_thr: illegal FIFO_DEPTH/AFULL_THR/AEMPTY_THR");
    end

    ptr_t       wr_ptr_r;
    ptr_t       rd_ptr_r;
    level_t     level_r;
    err_flags_t err_r;

    logic full_s;
    logic empty_s;
    logic wr_acc_s;
    logic rd_acc_s;
    logic ovf_set_s;
    logic unf_set_s;
    logic mem_we_s;

    assign full_s  = (level_r == DEPTH_L);
    assign empty_s = (level_r == level_t'(1'b0));

    // Flush blocks all traffic and error detection in its cycle
    assign wr_acc_s  = WEi & (~full_s | RDi) & ~FLUSHi;
    assign rd_acc_s  = RDi & ~empty_s & ~FLUSHi;
    assign ovf_set_s = WEi & full_s & ~RDi & ~FLUSHi;
    assign unf_set_s = RDi & empty_s & ~FLUSHi;
    assign mem_we_s  = wr_acc_s & RSTni;

    // Pointer, level and sticky error state
    always_ff @(posedge CLKip) begin
        if (!RSTni) begin
            wr_ptr_r <= ptr_t'(1'b0);
            rd_ptr_r <= ptr_t'(1'b0);
            level_r  <= level_t'(1'b0);
            err_r    <= '{ovf: 1'b0, unf: 1'b0};
        end else if (FLUSHi) begin
            wr_ptr_r <= ptr_t'(1'b0);
            rd_ptr_r <= ptr_t'(1'b0);
            level_r  <= level_t'(1'b0);
            err_r.ovf <= err_r.ovf & ~ERR_CLRi;
            err_r.unf <= err_r.unf & ~ERR_CLRi;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
            // A new error event outranks a simultaneous clear
            err_r.ovf <= ovf_set_s | (err_r.ovf & ~ERR_CLRi);
            err_r.unf <= unf_set_s | (err_r.unf & ~ERR_CLRi);
        end
    end

    fifo_mem_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_mem (
        .clk   (CLKip),
        .we    (mem_we_s),
        .waddr (wr_ptr_r),
        .wdata (DATAi),
        .raddr (rd_ptr_r),
        .rdata (DATAo)
    );

    assign FULLo   = full_s;
    assign EMPTYo  = empty_s;
    assign AFULLo  = (level_r >= AFULL_L);
    assign AEMPTYo = (level_r <= AEMPTY_L);
    assign LEVELo  = level_r;
    assign OVFo    = err_r.ovf;
    assign UNFo    = err_r.unf;

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Self-checking bench for sync_fifo_thr: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_sync_fifo_thr;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFT   = DEPTH - 2;
    localparam int AET   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] dout;
    logic          full, empty, afull, aempty, ovf, unf;
    logic [4:0]    level;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    sync_fifo_thr #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AFULL_THR  (AFT),
        .AEMPTY_THR (AET)
    ) dut (
        .CLKip    (clk),
        .RSTni    (rst_n),
        .FLUSHi   (flush),
        .WEi      (we),
        .DATAi    (din),
        .RDi      (rd),
        .ERR_CLRi (err_clr),
        .DATAo    (dout),
        .FULLo    (full),
        .EMPTYo   (empty),
        .AFULLo   (afull),
        .AEMPTYo  (aempty),
        .LEVELo   (level),
        .OVFo     (ovf),
        .UNFo     (unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("level",  32'(level),  32'(q.size()));
        check("empty",  32'(empty),  32'(q.size() == 0));
        check("full",   32'(full),   32'(q.size() == DEPTH));
        check("afull",  32'(afull),  32'(q.size() >= AFT));
        check("aempty", 32'(aempty), 32'(q.size() <= AET));
        check("ovf",    32'(ovf),    32'(m_ovf));
        check("unf",    32'(unf),    32'(m_unf));
        if (q.size() > 0) check("dout", 32'(dout), 32'(q[0]));
    endtask

    // One clock cycle: drive, let the edge happen, advance model, compare.
    task automatic step(input bit r_n, input bit fl, input bit w, input logic [DW-1:0] d,
                        input bit r, input bit ec);
        bit m_full, m_empty;
        rst_n = r_n; flush = fl; we = w; din = d; rd = r; err_clr = ec;
        @(posedge clk);
        m_full  = (q.size() == DEPTH);
        m_empty = (q.size() == 0);
        if (!r_n) begin
            q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
            m_ovf = (w && m_full && !r) || (m_ovf && !ec);
            m_unf = (r && m_empty) || (m_unf && !ec);
            if (r && !m_empty) void'(q.pop_front());
            if (w && (!m_full || r)) q.push_back(d);
        end
        #1;
        compare_all();
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_afull", 32'(afull), 32'd0);

        // Fill to full
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        check("full_after16", 32'(full), 32'd1);
        check("level16", 32'(level), 32'd16);

        // Rejected write sets OVF
        step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("level_hold16", 32'(level), 32'd16);

        // Write while full with a simultaneous read
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        check("wr_rd_full_dout", 32'(dout), 32'h02);
        check("wr_rd_full_level", 32'(level), 32'd16);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("drained", 32'(empty), 32'd1);

        // Read + write on empty: read rejected, write accepted
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        check("unf_set", 32'(unf), 32'd1);
        check("empty_wr_dout", 32'(dout), 32'h55);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clr", 32'(unf), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Pointer wrap with interleaved pairs
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            check("wrap_level_le2", 32'(level <= 5'd2), 32'd1);
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit fl, ec;
            fl = ($urandom_range(0, 59) == 0);
            ec = fl ? 1'b0 : ($urandom_range(0, 19) == 0);
            step(1'b1, fl, 1'($urandom_range(0, 99) < 55), 8'($urandom),
                 1'($urandom_range(0, 99) < 45), ec);
        end

        // Flush with a concurrent write; sticky flags survive
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check("flush_level", 32'(level), 32'd0);
        check("flush_unf_kept", 32'(unf), 32'd1);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_unf", 32'(unf), 32'd0);
        check("midrst_aempty", 32'(aempty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
